// File: rtl/otter_pipe_ctrl.sv
// otter_pipe_ctrl: stall/flush sequencer for the five-stage OTTER pipeline.
// Turns load-use, branch redirect, fetch-ready and data-memory handshake into
// per-stage write enables and bubble inserts; owns reset drain and a
// data-memory wait watchdog.
// Optional feature: define OTTER_PIPE_CTRL_PERF_EN to build the stall and
// redirect performance counters (otherwise both read as zero).
module otter_pipe_ctrl #(
  parameter int unsigned MAX_WAIT  = 255,
  parameter int unsigned RST_DRAIN = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load_use_haz,
  input  logic        br_taken,
  input  logic        imem_ack,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        if_de_we,
  output logic        de_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        flush_if_de,
  output logic        flush_de_ex,
  output logic        flush_mem_wb,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
);

  localparam int unsigned WAIT_W  = 16;
  localparam int unsigned DRAIN_W = 4;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_RUN       = 2'd1,
    ST_REDIRECT  = 2'd2,
    ST_DMEM_WAIT = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [DRAIN_W-1:0]  drain_cnt, drain_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic                mem_stall;
  logic                stall_fire;
  logic                redirect_fire;

  assign mem_stall = dmem_req && !dmem_ack;

  // Next-state and Mealy enable/flush decode, strict hazard priority
  always_comb begin
    state_nxt     = state;
    drain_nxt     = drain_cnt;
    pc_we         = 1'b1;
    if_de_we      = 1'b1;
    de_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    mem_wb_we     = 1'b1;
    flush_if_de   = 1'b0;
    flush_de_ex   = 1'b0;
    flush_mem_wb  = 1'b0;
    stall_fire    = 1'b0;
    redirect_fire = 1'b0;

    if (RST) begin
      state_nxt    = ST_RESET;
      drain_nxt    = '0;
      pc_we        = 1'b0;
      flush_if_de  = 1'b1;
      flush_de_ex  = 1'b1;
      flush_mem_wb = 1'b1;
    end else begin
      case (state)
        ST_RESET: begin
          pc_we        = 1'b0;
          flush_if_de  = 1'b1;
          flush_de_ex  = 1'b1;
          flush_mem_wb = 1'b1;
          if (drain_cnt == DRAIN_W'(RST_DRAIN - 1)) begin
            state_nxt = ST_RUN;
            drain_nxt = '0;
          end else begin
            drain_nxt = drain_cnt + DRAIN_W'(1);
          end
        end
        ST_RUN, ST_DMEM_WAIT: begin
          state_nxt = ST_RUN;
          if (mem_stall) begin
            // Freeze everything upstream of MEM; the frozen EX re-presents br/load-use
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            flush_mem_wb = 1'b1;
            stall_fire   = 1'b1;
            state_nxt    = ST_DMEM_WAIT;
          end else if (br_taken) begin
            flush_if_de   = 1'b1;
            flush_de_ex   = 1'b1;
            redirect_fire = 1'b1;
            state_nxt     = ST_REDIRECT;
          end else if (load_use_haz) begin
            pc_we       = 1'b0;
            if_de_we    = 1'b0;
            flush_de_ex = 1'b1;
          end else if (!imem_ack) begin
            pc_we       = 1'b0;
            flush_if_de = 1'b1;
          end
        end
        ST_REDIRECT: begin
          // DE and EX hold bubbles here, so br_taken and load_use_haz are ignored
          if (mem_stall) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            flush_mem_wb = 1'b1;
            stall_fire   = 1'b1;
          end else begin
            flush_if_de = 1'b1;
            state_nxt   = ST_RUN;
          end
        end
        default: state_nxt = ST_RESET;
      endcase
    end
  end

  // Saturating count of consecutive data-memory stall cycles
  always_comb begin
    wait_nxt = '0;
    if (stall_fire) begin
      if (wait_cnt >= WAIT_W'(MAX_WAIT)) wait_nxt = WAIT_W'(MAX_WAIT);
      else                               wait_nxt = wait_cnt + WAIT_W'(1);
    end
  end

  // State, drain counter and sticky watchdog registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_RESET;
      drain_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      drain_cnt   <= drain_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= mem_timeout || (wait_nxt == WAIT_W'(MAX_WAIT));
    end
  end

`ifdef OTTER_PIPE_CTRL_PERF_EN
  // Performance counters: PC-hold cycles outside reset, and redirects taken
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if ((state != ST_RESET) && !pc_we) stall_cycles <= stall_cycles + 32'd1;
      if (redirect_fire)                 redirect_count <= redirect_count + 32'd1;
    end
  end
`else
  assign stall_cycles   = 32'd0;
  assign redirect_count = 32'd0;
`endif

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Directed self-checking bench for otter_pipe_ctrl (MAX_WAIT=4, RST_DRAIN=4).
module tb_otter_pipe_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        load_use_haz = 1'b0;
  logic        br_taken = 1'b0;
  logic        imem_ack = 1'b1;
  logic        dmem_req = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we;
  logic        flush_if_de, flush_de_ex, flush_mem_wb, mem_timeout;
  logic [31:0] stall_cycles, redirect_count;

  int total = 0;
  int bad   = 0;

`ifdef OTTER_PIPE_CTRL_PERF_EN
  localparam int unsigned PERF = 1;
`else
  localparam int unsigned PERF = 0;
`endif

  // Expected {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we, flush_if_de, flush_de_ex, flush_mem_wb}
  localparam logic [7:0] V_RST   = 8'b01111_111;
  localparam logic [7:0] V_RUN   = 8'b11111_000;
  localparam logic [7:0] V_LU    = 8'b00111_010;
  localparam logic [7:0] V_NOACK = 8'b01111_100;
  localparam logic [7:0] V_BR    = 8'b11111_110;
  localparam logic [7:0] V_REDIR = 8'b11111_100;
  localparam logic [7:0] V_STALL = 8'b00001_001;

  // Stimulus {RST, load_use_haz, br_taken, imem_ack, dmem_req, dmem_ack}
  localparam logic [5:0] S_RST    = 6'b100100;
  localparam logic [5:0] S_IDLE   = 6'b000100;
  localparam logic [5:0] S_LU     = 6'b010100;
  localparam logic [5:0] S_BR     = 6'b001100;
  localparam logic [5:0] S_NOACK  = 6'b000000;
  localparam logic [5:0] S_STALL  = 6'b000110;
  localparam logic [5:0] S_ACK    = 6'b000111;
  localparam logic [5:0] S_STL_BL = 6'b011110;
  localparam logic [5:0] S_ACK_BL = 6'b011111;

  otter_pipe_ctrl #(.MAX_WAIT(4), .RST_DRAIN(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .load_use_haz  (load_use_haz),
    .br_taken      (br_taken),
    .imem_ack      (imem_ack),
    .dmem_req      (dmem_req),
    .dmem_ack      (dmem_ack),
    .pc_we         (pc_we),
    .if_de_we      (if_de_we),
    .de_ex_we      (de_ex_we),
    .ex_mem_we     (ex_mem_we),
    .mem_wb_we     (mem_wb_we),
    .flush_if_de   (flush_if_de),
    .flush_de_ex   (flush_de_ex),
    .flush_mem_wb  (flush_mem_wb),
    .mem_timeout   (mem_timeout),
    .stall_cycles  (stall_cycles),
    .redirect_count(redirect_count)
  );

  always #5 CLK = ~CLK;

  logic [7:0] ctl;
  assign ctl = {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we, flush_if_de, flush_de_ex, flush_mem_wb};

  // Drive one cycle of inputs mid-cycle and settle before sampling
  task automatic apply(input logic [5:0] s);
    @(negedge CLK);
    {RST, load_use_haz, br_taken, imem_ack, dmem_req, dmem_ack} = s;
    #1;
  endtask

  // Reset and drain so the next applied cycle is in RUN
  task automatic reset_pipe();
    apply(S_RST);
    apply(S_RST);
    for (int i = 0; i < 4; i++) apply(S_IDLE);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(S_RST);
      total++;
      if (ctl !== V_RST) begin
        bad++; $display("FAIL reset_hold[%0d]: ctl=%b expected %b", i, ctl, V_RST);
      end
      if (i > 0) begin
        total++;
        if ({mem_timeout, stall_cycles, redirect_count} !== 65'd0) begin
          bad++; $display("FAIL reset_regs[%0d]: to=%b stall=%0d redir=%0d expected 0", i, mem_timeout, stall_cycles, redirect_count);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      apply(S_IDLE);
      total++;
      if (ctl !== V_RST) begin
        bad++; $display("FAIL reset_drain[%0d]: ctl=%b expected %b", i, ctl, V_RST);
      end
    end
    apply(S_IDLE);
    total++;
    if (ctl !== V_RUN) begin
      bad++; $display("FAIL reset_run: ctl=%b expected %b", ctl, V_RUN);
    end
    total++;
    if ({mem_timeout, stall_cycles, redirect_count} !== 65'd0) begin
      bad++; $display("FAIL reset_run_regs: to=%b stall=%0d redir=%0d expected 0", mem_timeout, stall_cycles, redirect_count);
    end
  endtask

  task automatic test_load_use();
    logic [5:0] st [4] = '{S_LU, S_IDLE, S_NOACK, S_IDLE};
    logic [7:0] ex [4] = '{V_LU, V_RUN, V_NOACK, V_RUN};
    reset_pipe();
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      total++;
      if (ctl !== ex[i]) begin
        bad++; $display("FAIL load_use[%0d]: ctl=%b expected %b", i, ctl, ex[i]);
      end
    end
    total++;
    if (stall_cycles !== 32'(2 * PERF)) begin
      bad++; $display("FAIL load_use_stall_cnt: got %0d expected %0d", stall_cycles, 2 * PERF);
    end
  endtask

  task automatic test_branch();
    logic [5:0] st [9] = '{S_BR, S_IDLE, S_IDLE, S_BR, S_LU, S_BR, S_STALL, S_BR, S_IDLE};
    logic [7:0] ex [9] = '{V_BR, V_REDIR, V_RUN, V_BR, V_REDIR, V_BR, V_STALL, V_REDIR, V_RUN};
    reset_pipe();
    for (int i = 0; i < 9; i++) begin
      apply(st[i]);
      total++;
      if (ctl !== ex[i]) begin
        bad++; $display("FAIL branch[%0d]: ctl=%b expected %b", i, ctl, ex[i]);
      end
      if (i == 2) begin
        total++;
        if (redirect_count !== 32'(PERF)) begin
          bad++; $display("FAIL branch_redir_cnt: got %0d expected %0d", redirect_count, PERF);
        end
      end
    end
    total++;
    if ({redirect_count, stall_cycles} !== {32'(3 * PERF), 32'(PERF)}) begin
      bad++; $display("FAIL branch_counters: redir=%0d stall=%0d expected %0d %0d", redirect_count, stall_cycles, 3 * PERF, PERF);
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] st [5] = '{S_STL_BL, S_STL_BL, S_STL_BL, S_ACK_BL, S_IDLE};
    logic [7:0] ex [5] = '{V_STALL, V_STALL, V_STALL, V_BR, V_REDIR};
    reset_pipe();
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      total++;
      if (ctl !== ex[i]) begin
        bad++; $display("FAIL mem_wait[%0d]: ctl=%b expected %b", i, ctl, ex[i]);
      end
    end
    total++;
    if ({mem_timeout, stall_cycles, redirect_count} !== {1'b0, 32'(3 * PERF), 32'(PERF)}) begin
      bad++; $display("FAIL mem_wait_regs: to=%b stall=%0d redir=%0d expected 0 %0d %0d", mem_timeout, stall_cycles, redirect_count, 3 * PERF, PERF);
    end
  endtask

  task automatic test_watchdog();
    reset_pipe();
    for (int i = 0; i < 6; i++) begin
      apply(S_STALL);
      total++;
      if (ctl !== V_STALL) begin
        bad++; $display("FAIL wd_stall[%0d]: ctl=%b expected %b", i, ctl, V_STALL);
      end
      total++;
      if (mem_timeout !== (i >= 4)) begin
        bad++; $display("FAIL wd_timeout[%0d]: got %b expected %b", i, mem_timeout, (i >= 4));
      end
    end
    apply(S_ACK);
    total++;
    if ({ctl, mem_timeout} !== {V_RUN, 1'b1}) begin
      bad++; $display("FAIL wd_ack: ctl=%b to=%b expected %b 1", ctl, mem_timeout, V_RUN);
    end
    apply(S_IDLE);
    total++;
    if (mem_timeout !== 1'b1) begin
      bad++; $display("FAIL wd_sticky: got %b expected 1", mem_timeout);
    end
    apply(S_RST);
    total++;
    if (mem_timeout !== 1'b1) begin
      bad++; $display("FAIL wd_rst_cycle: got %b expected 1", mem_timeout);
    end
    apply(S_RST);
    total++;
    if (mem_timeout !== 1'b0) begin
      bad++; $display("FAIL wd_cleared: got %b expected 0", mem_timeout);
    end
  endtask

  task automatic test_reset_mid_redirect();
    logic [5:0] st [7] = '{S_BR, S_RST, S_IDLE, S_IDLE, S_IDLE, S_IDLE, S_IDLE};
    logic [7:0] ex [7] = '{V_BR, V_RST, V_RST, V_RST, V_RST, V_RST, V_RUN};
    reset_pipe();
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      total++;
      if (ctl !== ex[i]) begin
        bad++; $display("FAIL rst_redirect[%0d]: ctl=%b expected %b", i, ctl, ex[i]);
      end
      if (i == 2) begin
        total++;
        if ({stall_cycles, redirect_count} !== 64'd0) begin
          bad++; $display("FAIL rst_redirect_cnt: stall=%0d redir=%0d expected 0 0", stall_cycles, redirect_count);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_watchdog();
    test_reset_mid_redirect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_pipe_ctrl.md
# otter_pipe_ctrl

Pipeline stall/flush sequencer for the five-stage OTTER core. Combines the load-use hazard flag, EX-stage branch/jump redirect, instruction-fetch ready and data-memory handshake into per-stage register write-enables and bubble-insert controls. Sits beside the forwarding/hazard detection logic and drives the PC, IF/DE, DE/EX, EX/MEM and MEM/WB pipeline registers. Also owns the post-reset pipeline drain and a data-memory wait watchdog.

## Interface
- MAX_WAIT, 255: consecutive data-memory wait cycles before `mem_timeout` sets. Range 1..65535.
- RST_DRAIN, 4: cycles spent in RESET state after `RST` deasserts. Range 1..15.

- CLK  in  1  rising-edge clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- load_use_haz  in  1  DE instruction consumes a load result that is still in EX.
- br_taken  in  1  EX resolved a taken branch or jump; the PC mux selects the target this cycle.
- imem_ack  in  1  fetched instruction is valid this cycle.
- dmem_req  in  1  MEM-stage instruction is a load or store.
- dmem_ack  in  1  data memory completes the MEM-stage access this cycle.
- pc_we  out  1  PC register load enable.
- if_de_we, de_ex_we, ex_mem_we, mem_wb_we  out  1 each  pipeline register write enables.
- flush_if_de, flush_de_ex, flush_mem_wb  out  1 each  when the register is written, load a NOP and clear valid.
- mem_timeout  out  1  sticky watchdog error.
- stall_cycles  out  32  performance counter; 0 when the feature is compiled out.
- redirect_count  out  32  performance counter; 0 when the feature is compiled out.

## Operation
- States: RESET, RUN, REDIRECT, DMEM_WAIT. Two-bit state register plus a 4-bit drain counter.
- Outputs are Mealy: they depend on the current state and the current inputs.
- RESET outputs: pc_we=0. All four `*_we` are 1. All three flushes are 1.
  - `RST` high: forces RESET and drain_cnt=0.
  - After `RST` deasserts: drain_cnt increments each cycle. When drain_cnt==RST_DRAIN-1, the next state is RUN.
- RUN/DMEM_WAIT: inputs are resolved in strict priority. Any signal not listed is 1 for `*_we` and 0 for flushes.
  1. Data-memory stall, dmem_req && !dmem_ack:
     - pc_we, if_de_we, de_ex_we, ex_mem_we = 0.
     - mem_wb_we=1 and flush_mem_wb=1.
     - Next state is DMEM_WAIT.
     - br_taken and load_use_haz are ignored; the frozen EX re-presents them later.
  2. br_taken:
     - pc_we=1, flush_if_de=1, flush_de_ex=1.
     - Next state is REDIRECT.
  3. load_use_haz:
     - pc_we=0, if_de_we=0, flush_de_ex=1.
  4. !imem_ack:
     - pc_we=0, flush_if_de=1.
  5. Otherwise all stages advance.
  - Leaving DMEM_WAIT: when no stall is present, the state returns to RUN. The same cycle's priorities 2–5 apply.
- REDIRECT covers the synchronous-memory fetch latency.
  - Lasts exactly one cycle: flush_if_de=1, pc_we=1, other stages advance. Next state is RUN.
  - A data-memory stall in REDIRECT applies priority 1 and the state stays REDIRECT.
  - load_use_haz and br_taken are ignored in REDIRECT, because DE and EX hold bubbles.
- Watchdog:
  - wait_cnt increments every cycle in which priority 1 fires. It clears on any cycle in which it does not fire. It saturates at MAX_WAIT.
  - mem_timeout is set on the cycle after wait_cnt reaches MAX_WAIT. It stays set until `RST`.
  - Stall outputs keep following the inputs after timeout; the watchdog does not recover the pipeline.

## Timing
- Zero-cycle control latency: the inputs in cycle N determine the register enables that take effect at the edge ending cycle N.
- Redirect penalty: 2 cycles. These are the br_taken cycle plus the REDIRECT cycle; 2 consecutive IF/DE bubbles plus 1 DE/EX bubble.
- Load-use penalty: 1 bubble per cycle that load_use_haz is asserted.
- Reset values, registered outputs:
  - state=RESET, mem_timeout=0, wait_cnt=0, counters=0.
- Reset values, combinational outputs while `RST` is high:
  - pc_we=0, all `*_we`=1, all flushes=1.
- `RST` asserted mid-stall or mid-REDIRECT: the next cycle is RESET. No pending redirect is preserved.

## Configuration
- `OTTER_PIPE_CTRL_PERF_EN` defined:
  - stall_cycles increments on every cycle outside RESET in which pc_we=0.
  - redirect_count increments on every cycle in which priority 2 fires.
  - Both counters are 32-bit, wrap modulo 2^32, and clear on `RST`.
- `OTTER_PIPE_CTRL_PERF_EN` undefined: no counter flops are built and both outputs are tied to 32'd0. All other behaviour is identical.

## Test plan
- Reset drain: hold RST 3 cycles, then release.
  - Expect 4 cycles with pc_we=0 and all flushes=1, then RUN.
  - With all inputs idle and imem_ack=1, expect all `*_we`=1 and no flush.
- Load-use: assert load_use_haz for 1 cycle in RUN.
  - That cycle: pc_we=0, if_de_we=0, flush_de_ex=1.
  - The next cycle is normal.
- Branch: pulse br_taken for 1 cycle.
  - Cycle 0: flush_if_de=1, flush_de_ex=1, pc_we=1.
  - Cycle 1 (REDIRECT): flush_if_de=1, flush_de_ex=0.
  - Cycle 2: RUN, no flush.
  - With the perf feature on, redirect_count=1.
- Memory wait: dmem_req=1 with dmem_ack low for 3 cycles, while br_taken=1 and load_use_haz=1.
  - Each stall cycle: only mem_wb_we=1 and flush_mem_wb=1.
  - On the ack cycle: the branch redirect fires.
  - With the perf feature on, stall_cycles=3.
- Watchdog: with MAX_WAIT=4, hold dmem_req=1 and dmem_ack=0 for 6 cycles.
  - mem_timeout rises on the cycle after the 4th stall cycle.
  - It stays 1 after the ack.
  - It clears only on RST.
- Reset mid-REDIRECT: assert RST during the REDIRECT cycle.
  - Next cycle: state is RESET, pc_we=0, counters=0.
